// File: rtl/spsram_bank_ctrl.sv
// spsram_bank_ctrl: initiator-side controller for a bank array of spsram
// macros. Accepts valid/ready read/write requests, decodes the top address
// bits into a one-hot chip enable, drives the shared registered bank pins and
// returns read data on a valid/ready response port.
// Optional build macro: SPSRAM_CTRL_ASYNC_RD_EN (combinational-read banks,
// RD_WAIT skipped, 2-cycle accept-to-response latency instead of 3).
module spsram_bank_ctrl #(
    parameter  int BW_DATA  = 64,
    parameter  int BW_ADDR  = 6,
    parameter  int BW_BSEL  = 2,
    localparam int NUM_BANK = 1 << BW_BSEL,
    localparam int BW_MADDR = BW_ADDR - BW_BSEL
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_wr,
    input  logic [BW_ADDR-1:0]          i_req_addr,
    input  logic [BW_DATA-1:0]          i_req_data,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [BW_DATA-1:0]          o_rsp_data,
    output logic                        o_busy,
    output logic [BW_DATA-1:0]          o_mem_data,
    output logic [BW_MADDR-1:0]         o_mem_addr,
    output logic                        o_mem_wen,
    output logic                        o_mem_oen,
    output logic [NUM_BANK-1:0]         o_mem_cen,
    input  logic [NUM_BANK*BW_DATA-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RSP
    } state_t;

    state_t                state, state_n;
    logic [BW_BSEL-1:0]    bank_q, bank_n;
    logic [NUM_BANK-1:0]   cen_n;
    logic                  wen_n, oen_n;
    logic [BW_MADDR-1:0]   addr_n;
    logic [BW_DATA-1:0]    data_n;
    logic [BW_DATA-1:0]    rsp_data_n;
    logic                  accept;
    logic                  capture;

    // Ready and status flags come from the state register only.
    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RSP);
    assign o_busy      = (state != IDLE);
    assign accept      = i_req_valid && o_req_ready;

    // Next-state and next bank-pin values; pins default to idle, addr/data hold.
    always_comb begin
        state_n    = state;
        bank_n     = bank_q;
        cen_n      = '0;
        wen_n      = 1'b0;
        oen_n      = 1'b0;
        addr_n     = o_mem_addr;
        data_n     = o_mem_data;
        rsp_data_n = o_rsp_data;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bank_n = i_req_addr[BW_ADDR-1 -: BW_BSEL];
                    addr_n = i_req_addr[BW_MADDR-1:0];
                    cen_n  = NUM_BANK'(1) << i_req_addr[BW_ADDR-1 -: BW_BSEL];
                    if (i_req_wr) begin
                        wen_n  = 1'b1;
                        data_n = i_req_data;
                    end else begin
                        oen_n   = 1'b1;
                        state_n = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
`ifdef SPSRAM_CTRL_ASYNC_RD_EN
                capture = 1'b1;
                state_n = RSP;
`else
                cen_n   = o_mem_cen;
                oen_n   = 1'b1;
                state_n = RD_WAIT;
`endif
            end
            RD_WAIT: begin
                capture = 1'b1;
                state_n = RSP;
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (capture) begin
            rsp_data_n = i_mem_rdata[int'(bank_q)*BW_DATA +: BW_DATA];
        end
    end

    // State, latched bank index, registered bank pins and response data.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= IDLE;
            bank_q     <= '0;
            o_mem_cen  <= '0;
            o_mem_wen  <= 1'b0;
            o_mem_oen  <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_rsp_data <= '0;
        end else begin
            state      <= state_n;
            bank_q     <= bank_n;
            o_mem_cen  <= cen_n;
            o_mem_wen  <= wen_n;
            o_mem_oen  <= oen_n;
            o_mem_addr <= addr_n;
            o_mem_data <= data_n;
            o_rsp_data <= rsp_data_n;
        end
    end

endmodule

// File: tb/tb_spsram_bank_ctrl.sv
// Testbench for spsram_bank_ctrl with 4 behavioural spsram banks x 16 words.
// Honours SPSRAM_CTRL_ASYNC_RD_EN for the bank read model and latency.
module tb_spsram_bank_ctrl;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;
    localparam int BW_BSEL = 2;
    localparam int NB      = 4;
`ifdef SPSRAM_CTRL_ASYNC_RD_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic               i_clk;
    logic               i_rstn;
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_wr;
    logic [5:0]         i_req_addr;
    logic [63:0]        i_req_data;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [63:0]        o_rsp_data;
    logic               o_busy;
    logic [63:0]        o_mem_data;
    logic [3:0]         o_mem_addr;
    logic               o_mem_wen;
    logic               o_mem_oen;
    logic [3:0]         o_mem_cen;
    logic [NB*64-1:0]   i_mem_rdata;

    int checks = 0;
    int errors = 0;

    spsram_bank_ctrl #(
        .BW_DATA(BW_DATA),
        .BW_ADDR(BW_ADDR),
        .BW_BSEL(BW_BSEL)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wr    (i_req_wr),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_busy      (o_busy),
        .o_mem_data  (o_mem_data),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wen   (o_mem_wen),
        .o_mem_oen   (o_mem_oen),
        .o_mem_cen   (o_mem_cen),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural spsram banks
    logic [63:0] mem   [NB][16];
    logic [63:0] rdata [NB];

    always @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (o_mem_cen[b]) begin
                if (o_mem_wen) mem[b][o_mem_addr] <= o_mem_data;
`ifndef SPSRAM_CTRL_ASYNC_RD_EN
                else if (o_mem_oen) rdata[b] <= mem[b][o_mem_addr];
`endif
            end
        end
    end

`ifdef SPSRAM_CTRL_ASYNC_RD_EN
    always_comb begin
        for (int b = 0; b < NB; b++) rdata[b] = mem[b][o_mem_addr];
    end
`endif

    for (genvar g = 0; g < NB; g++) begin : g_pack
        assign i_mem_rdata[g*64 +: 64] = rdata[g];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: flat 64-word memory plus a read age counter.
    logic [63:0] shadow [64];
    logic        m_on = 1'b0;
    logic        e_ready, e_valid, e_busy, e_wen, e_oen;
    logic [3:0]  e_cen, e_addr;
    logic [63:0] e_data, e_rsp_data;
    logic        rd_pend;
    int          rd_age;
    logic [5:0]  rd_addr;

    initial begin
        logic acc, done;
        forever begin
            @(negedge i_clk);
            if (m_on) begin
                chk("req_ready", 64'(o_req_ready), 64'(e_ready));
                chk("rsp_valid", 64'(o_rsp_valid), 64'(e_valid));
                chk("rsp_data",  o_rsp_data,       e_rsp_data);
                chk("busy",      64'(o_busy),      64'(e_busy));
                chk("mem_cen",   64'(o_mem_cen),   64'(e_cen));
                chk("mem_wen",   64'(o_mem_wen),   64'(e_wen));
                chk("mem_oen",   64'(o_mem_oen),   64'(e_oen));
                chk("mem_addr",  64'(o_mem_addr),  64'(e_addr));
                chk("mem_data",  o_mem_data,       e_data);
            end
            if (!i_rstn) begin
                m_on = 1'b1;
                rd_pend = 1'b0; rd_age = 0;
                e_cen = '0; e_wen = 1'b0; e_oen = 1'b0;
                e_addr = '0; e_data = '0; e_rsp_data = '0;
            end else begin
                acc  = i_req_valid && e_ready;
                done = e_valid && i_rsp_ready;
                e_cen = '0; e_wen = 1'b0; e_oen = 1'b0;
                if (acc && i_req_wr) begin
                    shadow[i_req_addr] = i_req_data;
                    e_cen  = 4'b0001 << i_req_addr[5:4];
                    e_wen  = 1'b1;
                    e_addr = i_req_addr[3:0];
                    e_data = i_req_data;
                end else if (acc) begin
                    rd_pend = 1'b1; rd_age = 1; rd_addr = i_req_addr;
                    e_cen  = 4'b0001 << i_req_addr[5:4];
                    e_oen  = 1'b1;
                    e_addr = i_req_addr[3:0];
                end else if (rd_pend) begin
                    if (done) begin
                        rd_pend = 1'b0;
                    end else if (rd_age < LAT) begin
                        rd_age++;
                        if (rd_age < LAT) begin
                            e_cen = 4'b0001 << rd_addr[5:4];
                            e_oen = 1'b1;
                        end else begin
                            e_rsp_data = shadow[rd_addr];
                        end
                    end
                end
            end
            e_valid = rd_pend && (rd_age == LAT);
            e_ready = !rd_pend;
            e_busy  = rd_pend;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!o_rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_read(input logic [5:0] a, input logic [63:0] exp);
        int lat;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = a;
        tick();
        i_req_valid = 1'b0;
        wait_rsp(lat);
        chk("rd_latency", 64'(lat), 64'(LAT));
        chk("rd_data", o_rsp_data, exp);
        if (i_rsp_ready) tick();
    endtask

    logic [3:0] cen_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        int lat;
        // 1: reset with a pending request
        i_rstn = 1'b0; i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 6'd5;
        i_req_data = '0; i_rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cen", 64'(o_mem_cen), 64'h0);
        chk("rst_wen_oen", 64'({o_mem_wen, o_mem_oen}), 64'h0);
        chk("rst_addr", 64'(o_mem_addr), 64'h0);
        chk("rst_data", o_mem_data, 64'h0);
        chk("rst_rsp", 64'({o_rsp_valid, o_busy}), 64'h0);
        chk("rst_rsp_data", o_rsp_data, 64'h0);
        i_req_valid = 1'b0; i_rstn = 1'b1;
        tick();
        chk("rst_ready", 64'(o_req_ready), 64'h1);

        // 2: back-to-back writes, data = addr
        for (int i = 0; i < 64; i++) begin
            i_req_valid = 1'b1; i_req_wr = 1'b1;
            i_req_addr = 6'(i); i_req_data = 64'(i);
            tick();
            chk("wr_cen", 64'(o_mem_cen), 64'(cen_tbl[i/16]));
            chk("wr_addr", 64'(o_mem_addr), 64'(i % 16));
            chk("wr_wen", 64'(o_mem_wen), 64'h1);
        end
        i_req_valid = 1'b0;
        tick();

        // 3: read everything back
        for (int i = 0; i < 64; i++) do_read(6'(i), 64'(i));

        // 4: stalled response at addr 37; intervening request ignored
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 6'd37;
        tick();
        i_req_valid = 1'b0;
        wait_rsp(lat);
        chk("stall_latency", 64'(lat), 64'(LAT));
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 6'd1; i_req_data = 64'hBAD;
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 64'(o_rsp_valid), 64'h1);
            chk("stall_data", o_rsp_data, 64'd37);
            chk("stall_ready", 64'(o_req_ready), 64'h0);
            chk("stall_cen", 64'(o_mem_cen), 64'h0);
            tick();
        end
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        tick();
        chk("stall_release", 64'({o_rsp_valid, o_req_ready}), 64'h1);
        do_read(6'd1, 64'd1);

        // 5: reset during the read, then retry
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 6'd20;
        tick();
        i_req_valid = 1'b0;
        repeat (LAT - 2) tick();
        i_rstn = 1'b0;
        tick();
        chk("midrst_valid", 64'(o_rsp_valid), 64'h0);
        chk("midrst_busy", 64'(o_busy), 64'h0);
        chk("midrst_ready", 64'(o_req_ready), 64'h1);
        i_rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_no_rsp", 64'(o_rsp_valid), 64'h0);
        end
        do_read(6'd20, 64'd20);

        // 6: write followed immediately by a read of the same word
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 6'd63;
        i_req_data = 64'hDEAD_BEEF;
        tick();
        do_read(6'd63, 64'hDEAD_BEEF);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
